// File: rtl/packed_bank_pkg.sv
// Shared constants and types for the packed register bank and its arbiter.
// Default geometry is 4 requesters sharing a 16 x 9-bit bank.
package packed_bank_pkg;
  localparam int PB_NUM_REQ = 4;
  localparam int PB_DEPTH   = 16;
  localparam int PB_WIDTH   = 9;

  typedef logic [PB_WIDTH-1:0]                entry_t;
  typedef logic [PB_DEPTH-1:0][PB_WIDTH-1:0]  bank_t;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping; combinational, no latency.
// When en is low gnt is all-zero (gnt_idx still reflects the would-be winner).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);
  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/packed_bank_arbiter.sv
// Round-robin shared access to a packed register bank; one access per accepting cycle, 1-cycle response.
// A held response (rsp_ready low) stalls all grants; out-of-range addresses respond with rsp_err.
module packed_bank_arbiter
  import packed_bank_pkg::*;
#(
  parameter int NUM_REQ = PB_NUM_REQ,
  parameter int DEPTH   = PB_DEPTH,
  parameter int WIDTH   = PB_WIDTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_write,
  output logic                      rsp_err,
  output logic [WIDTH-1:0]          rsp_data
);
  typedef logic [DEPTH-1:0][WIDTH-1:0] store_t;

  state_t            state;
  store_t            bank;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   g_idx;
  logic [ID_W-1:0]   nxt_ptr;
  logic              accept;
  logic              hs;
  logic              sel_write;
  logic              sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_wdata;

  assign accept = (state == IDLE) | rsp_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (accept),
    .gnt     (req_ready),
    .gnt_idx (g_idx)
  );

  assign hs        = |(req_valid & req_ready);
  assign sel_write = req_write[g_idx];
  assign sel_addr  = req_addr[int'(g_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(g_idx)*WIDTH +: WIDTH];
  assign sel_err   = (int'(sel_addr) >= DEPTH);
  assign nxt_ptr   = (int'(g_idx) == NUM_REQ-1) ? '0 : g_idx + 1'b1;

  // Reads capture the pre-edge entry; a same-edge write only lands in the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bank      <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else if (hs) begin
      if (sel_write && !sel_err) bank[sel_addr] <= sel_wdata;
      rsp_data  <= (!sel_write && !sel_err) ? bank[sel_addr] : '0;
      rsp_err   <= sel_err;
      rsp_write <= sel_write;
      rsp_id    <= g_idx;
      rsp_valid <= 1'b1;
      rr_ptr    <= nxt_ptr;
      state     <= RESP;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      state     <= IDLE;
    end
  end
endmodule
